fifo_mem_bank: RTL and testbench

//   Single-clock, two-port storage array for the FIFO datapath; next generation of the FIFO RAM.

---
 rtl/fifo_mem_bank.sv | 238 +++++++++++++++++++++++
 tb/tb_fifo_mem_bank.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mem_bank.sv
// rtl/fifo_mem_bank.sv - FIFO storage array: byte-lane writes, pipelined reads, sequential clear engine.
// Optional per-lane even parity is built when FIFO_MEM_PARITY_EN is defined.
module fifo_mem_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYTE_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                           clk_write,
    input  logic                           RST,
    input  logic                           i_init,
    output logic                           o_busy,
    input  logic [ADDR_WIDTH-1:0]          i_wr_addr,
    input  logic [DATA_WIDTH-1:0]          i_wr_data,
    input  logic                           i_wr_en,
    input  logic [DATA_WIDTH/BYTE_W-1:0]   i_wr_be,
`ifdef FIFO_MEM_PARITY_EN
    input  logic                           i_par_inj,
    output logic                           o_par_err,
`endif
    input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
    input  logic                           i_rd_en,
    output logic [DATA_WIDTH-1:0]          o_rd_data,
    output logic                           o_rd_valid
);

    localparam int LANES = DATA_WIDTH / BYTE_W;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [ADDR_WIDTH-1:0]   w_clr_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_idle;
    logic                    w_wr_in_range;
    logic                    w_rd_in_range;
    logic                    w_wr_do;
    logic                    w_rd_do;
    logic                    w_rdw_hit;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_data;
    logic                    w_out_valid;
    logic [DATA_WIDTH-1:0]   w_out_data;

    always_ff @(posedge clk_write or negedge RST) begin
        if (!RST) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_init) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                // i_init is deliberately not looked at here: a running clear is never restarted
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    assign w_idle = (r_state == S_IDLE);
    assign o_busy = ~w_idle;

    generate
        if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
            assign w_wr_in_range = 1'b1;
            assign w_rd_in_range = 1'b1;
        end else begin : g_part_range
            assign w_wr_in_range = (i_wr_addr < ADDR_WIDTH'(DEPTH));
            assign w_rd_in_range = (i_rd_addr < ADDR_WIDTH'(DEPTH));
        end
    endgenerate

    assign w_wr_do   = w_idle & i_wr_en & w_wr_in_range;
    assign w_rd_do   = w_idle & i_rd_en;
    assign w_rdw_hit = (RDW_MODE == 1) && w_wr_do && (i_wr_addr == i_rd_addr);

    always_ff @(posedge clk_write) begin
        if (!w_idle) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_do) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_wr_be[k]) begin
                    r_mem[i_wr_addr][k*BYTE_W +: BYTE_W] <= i_wr_data[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Out-of-range reads still produce a valid beat, just with a zero word
    always_comb begin
        w_rd_word = w_rd_in_range ? r_mem[i_rd_addr] : '0;
        if (w_rdw_hit) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_wr_be[k]) begin
                    w_rd_word[k*BYTE_W +: BYTE_W] = i_wr_data[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk_write or negedge RST) begin
        if (!RST) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_do;
            r_s1_data  <= w_rd_do ? w_rd_word : '0;
        end
    end

`ifdef FIFO_MEM_PARITY_EN
    logic [LANES-1:0] r_par [DEPTH];
    logic [LANES-1:0] w_wr_par;
    logic [LANES-1:0] w_rd_par;
    logic             w_rd_perr;
    logic             r_s1_perr;
    logic             w_out_perr;

    always_comb begin
        w_wr_par = '0;
        for (int k = 0; k < LANES; k++) begin
            w_wr_par[k] = (^i_wr_data[k*BYTE_W +: BYTE_W]) ^ i_par_inj;
        end
    end

    always_ff @(posedge clk_write) begin
        if (!w_idle) begin
            r_par[r_clr_cnt] <= '0;
        end else if (w_wr_do) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_wr_be[k]) begin
                    r_par[i_wr_addr][k] <= w_wr_par[k];
                end
            end
        end
    end

    always_comb begin
        w_rd_par = w_rd_in_range ? r_par[i_rd_addr] : '0;
        if (w_rdw_hit) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_wr_be[k]) begin
                    w_rd_par[k] = w_wr_par[k];
                end
            end
        end
        w_rd_perr = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if ((^w_rd_word[k*BYTE_W +: BYTE_W]) != w_rd_par[k]) begin
                w_rd_perr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_write or negedge RST) begin
        if (!RST) begin
            r_s1_perr <= 1'b0;
        end else begin
            r_s1_perr <= w_rd_do & w_rd_perr;
        end
    end
`endif

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  r_s2_valid;
            logic [DATA_WIDTH-1:0] r_s2_data;

            always_ff @(posedge clk_write or negedge RST) begin
                if (!RST) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    r_s2_data  <= r_s1_data;
                end
            end
            assign w_out_valid = r_s2_valid;
            assign w_out_data  = r_s2_data;
`ifdef FIFO_MEM_PARITY_EN
            logic r_s2_perr;
            always_ff @(posedge clk_write or negedge RST) begin
                if (!RST) begin
                    r_s2_perr <= 1'b0;
                end else begin
                    r_s2_perr <= r_s1_perr;
                end
            end
            assign w_out_perr = r_s2_perr;
`endif
        end else begin : g_lat1
            assign w_out_valid = r_s1_valid;
            assign w_out_data  = r_s1_data;
`ifdef FIFO_MEM_PARITY_EN
            assign w_out_perr  = r_s1_perr;
`endif
        end
    endgenerate

    assign o_rd_valid = w_out_valid;
    assign o_rd_data  = w_out_valid ? w_out_data : '0;
`ifdef FIFO_MEM_PARITY_EN
    assign o_par_err  = w_out_valid & w_out_perr;
`endif

endmodule

// File: tb/tb_fifo_mem_bank.sv
// tb/tb_fifo_mem_bank.sv - directed self-checking bench for fifo_mem_bank (three configurations).
module tb_fifo_mem_bank;

    logic        clk_write = 1'b0;
    logic        rst_n     = 1'b0;
    logic        init      = 1'b0;
    logic        wr_en     = 1'b0;
    logic        rd_en     = 1'b0;
    logic [4:0]  wr_addr   = '0;
    logic [4:0]  rd_addr   = '0;
    logic [7:0]  wd0       = '0;
    logic [0:0]  be0       = '0;
    logic [15:0] wd1       = '0;
    logic [1:0]  be1       = '0;
    logic        par_inj   = 1'b0;

    logic        busy0, busy1, busy2;
    logic [7:0]  rdata0, rdata2;
    logic [15:0] rdata1;
    logic        rvalid0, rvalid1, rvalid2;
`ifdef FIFO_MEM_PARITY_EN
    logic        perr0, perr1, perr2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_write = ~clk_write;

    fifo_mem_bank #(.DATA_WIDTH(8), .DEPTH(32), .ADDR_WIDTH(5), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(0)) dut0 (
        .clk_write(clk_write), .RST(rst_n), .i_init(init), .o_busy(busy0),
        .i_wr_addr(wr_addr), .i_wr_data(wd0), .i_wr_en(wr_en), .i_wr_be(be0),
`ifdef FIFO_MEM_PARITY_EN
        .i_par_inj(par_inj), .o_par_err(perr0),
`endif
        .i_rd_addr(rd_addr), .i_rd_en(rd_en), .o_rd_data(rdata0), .o_rd_valid(rvalid0)
    );

    fifo_mem_bank #(.DATA_WIDTH(16), .DEPTH(32), .ADDR_WIDTH(5), .BYTE_W(8), .RD_LATENCY(2), .RDW_MODE(1)) dut1 (
        .clk_write(clk_write), .RST(rst_n), .i_init(init), .o_busy(busy1),
        .i_wr_addr(wr_addr), .i_wr_data(wd1), .i_wr_en(wr_en), .i_wr_be(be1),
`ifdef FIFO_MEM_PARITY_EN
        .i_par_inj(par_inj), .o_par_err(perr1),
`endif
        .i_rd_addr(rd_addr), .i_rd_en(rd_en), .o_rd_data(rdata1), .o_rd_valid(rvalid1)
    );

    fifo_mem_bank #(.DATA_WIDTH(8), .DEPTH(20), .ADDR_WIDTH(5), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(0)) dut2 (
        .clk_write(clk_write), .RST(rst_n), .i_init(init), .o_busy(busy2),
        .i_wr_addr(wr_addr), .i_wr_data(wd0), .i_wr_en(wr_en), .i_wr_be(be0),
`ifdef FIFO_MEM_PARITY_EN
        .i_par_inj(par_inj), .o_par_err(perr2),
`endif
        .i_rd_addr(rd_addr), .i_rd_en(rd_en), .o_rd_data(rdata2), .o_rd_valid(rvalid2)
    );

    task automatic tick;
        @(posedge clk_write);
        #1;
    endtask

    // Counts edges until both clear engines drop busy; bounded so a stuck engine cannot hang the run
    task automatic count_clear(output int n0, output int n2);
        int n;
        n = 0; n0 = -1; n2 = -1;
        while ((busy0 || busy2) && n < 100) begin
            tick();
            n++;
            if (!busy0 && n0 < 0) n0 = n;
            if (!busy2 && n2 < 0) n2 = n;
        end
    endtask

    task automatic test_reset;
        int n0, n2;
        logic [4:0] addrs [4];
        addrs = '{5'd0, 5'd13, 5'd19, 5'd31};
        rst_n = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
            failures++; $display("FAIL reset_busy got=%b%b%b exp=111", busy0, busy1, busy2);
        end
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'h00 || rvalid1 !== 1'b0 || rdata1 !== 16'h0000) begin
            failures++; $display("FAIL reset_rd got v0=%b d0=%h v1=%b d1=%h exp zeros", rvalid0, rdata0, rvalid1, rdata1);
        end
`ifdef FIFO_MEM_PARITY_EN
        checks++;
        if (perr0 !== 1'b0) begin
            failures++; $display("FAIL reset_perr got=%b exp=0", perr0);
        end
`endif
        rst_n = 1'b1;
        count_clear(n0, n2);
        checks++;
        if (n0 != 32) begin
            failures++; $display("FAIL reset_clear_len_d32 got=%0d exp=32", n0);
        end
        checks++;
        if (n2 != 20) begin
            failures++; $display("FAIL reset_clear_len_d20 got=%0d exp=20", n2);
        end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_addr = addrs[i];
            tick();
            checks++;
            if (rvalid0 !== 1'b1 || rdata0 !== 8'h00) begin
                failures++; $display("FAIL reset_read_zero a=%0d got v=%b d=%h exp v=1 d=00", addrs[i], rvalid0, rdata0);
            end
        end
        rd_en = 1'b0;
        tick(); tick();
    endtask

    task automatic test_read_latency;
        wr_en = 1'b1; wr_addr = 5'd3; wd0 = 8'hA5; be0 = 1'b1; wd1 = 16'h00A5; be1 = 2'b11;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd3;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'hA5) begin
            failures++; $display("FAIL lat1_read got v=%b d=%h exp v=1 d=a5", rvalid0, rdata0);
        end
        checks++;
        if (rvalid1 !== 1'b0 || rdata1 !== 16'h0000) begin
            failures++; $display("FAIL lat2_early got v=%b d=%h exp v=0 d=0000", rvalid1, rdata1);
        end
        tick();
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 16'h00A5) begin
            failures++; $display("FAIL lat2_read got v=%b d=%h exp v=1 d=00a5", rvalid1, rdata1);
        end
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'h00) begin
            failures++; $display("FAIL lat1_drop got v=%b d=%h exp v=0 d=00", rvalid0, rdata0);
        end
        tick();
    endtask

    task automatic test_byte_enable;
        wr_en = 1'b1; wr_addr = 5'd7; wd1 = 16'h1234; be1 = 2'b11; wd0 = 8'h5A; be0 = 1'b1;
        tick();
        wd1 = 16'hABCD; be1 = 2'b10; wd0 = 8'hFF; be0 = 1'b0;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd7;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rdata0 !== 8'h5A) begin
            failures++; $display("FAIL be_zero_noop got=%h exp=5a", rdata0);
        end
        tick();
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 16'hAB34) begin
            failures++; $display("FAIL be_lane_merge got v=%b d=%h exp v=1 d=ab34", rvalid1, rdata1);
        end
        tick();
    endtask

    task automatic test_rdw;
        wr_en = 1'b1; wr_addr = 5'd5; wd0 = 8'h11; be0 = 1'b1; wd1 = 16'h1111; be1 = 2'b11;
        tick();
        wd0 = 8'h77; wd1 = 16'h7777; be1 = 2'b01; rd_en = 1'b1; rd_addr = 5'd5;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        checks++;
        if (rdata0 !== 8'h11) begin
            failures++; $display("FAIL rdw_old_data got=%h exp=11", rdata0);
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if (rdata1 !== 16'h1177) begin
            failures++; $display("FAIL rdw_new_merged got=%h exp=1177", rdata1);
        end
        checks++;
        if (rdata0 !== 8'h77) begin
            failures++; $display("FAIL rdw_after_write got=%h exp=77", rdata0);
        end
        tick(); tick();
    endtask

    task automatic test_out_of_range;
        wr_en = 1'b1; wr_addr = 5'd25; wd0 = 8'h99; be0 = 1'b1;
        tick();
        wr_addr = 5'd19; wd0 = 8'h42;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd25;
        tick();
        checks++;
        if (rvalid2 !== 1'b1 || rdata2 !== 8'h00) begin
            failures++; $display("FAIL oor_read got v=%b d=%h exp v=1 d=00", rvalid2, rdata2);
        end
        checks++;
        if (rdata0 !== 8'h99) begin
            failures++; $display("FAIL inrange_read got=%h exp=99", rdata0);
        end
        rd_addr = 5'd19;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rvalid2 !== 1'b1 || rdata2 !== 8'h42) begin
            failures++; $display("FAIL last_entry_read got v=%b d=%h exp v=1 d=42", rvalid2, rdata2);
        end
        tick();
    endtask

    task automatic test_clear;
        int n;
        int n0;
        wr_en = 1'b1; be0 = 1'b1; be1 = 2'b11;
        for (int i = 0; i < 32; i++) begin
            wr_addr = 5'(i); wd0 = 8'(i + 1); wd1 = 16'(i + 1);
            tick();
        end
        wr_en = 1'b0; init = 1'b1; rd_en = 1'b1; rd_addr = 5'd4;
        tick();
        init = 1'b0; rd_en = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || rvalid0 !== 1'b1 || rdata0 !== 8'h05) begin
            failures++; $display("FAIL clear_inflight got busy=%b v=%b d=%h exp 1 1 05", busy0, rvalid0, rdata0);
        end
        n = 0; n0 = -1;
        while (busy0 && n < 100) begin
            if (n == 10) begin
                init = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wd0 = 8'hEE; rd_en = 1'b1; rd_addr = 5'd6;
            end else begin
                init = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
            end
            tick();
            n++;
            if (n == 11) begin
                checks++;
                if (rvalid0 !== 1'b0) begin
                    failures++; $display("FAIL busy_read_ignored got v=%b exp=0", rvalid0);
                end
            end
            if (!busy0) n0 = n;
        end
        init = 1'b0; wr_en = 1'b0;
        checks++;
        if (n0 != 32) begin
            failures++; $display("FAIL init_clear_len got=%0d exp=32", n0);
        end
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1; rd_addr = 5'(i);
            tick();
            checks++;
            if (rvalid0 !== 1'b1 || rdata0 !== 8'h00) begin
                failures++; $display("FAIL cleared_read a=%0d got v=%b d=%h exp v=1 d=00", i, rvalid0, rdata0);
            end
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if (rdata1 !== 16'h0000) begin
            failures++; $display("FAIL cleared_read_w16 got=%h exp=0000", rdata1);
        end
        tick();
    endtask

    task automatic test_parity;
`ifdef FIFO_MEM_PARITY_EN
        wr_en = 1'b1; wr_addr = 5'd9; wd0 = 8'h3C; be0 = 1'b1; par_inj = 1'b1;
        tick();
        wr_en = 1'b0; par_inj = 1'b0; rd_en = 1'b1; rd_addr = 5'd9;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rvalid0 !== 1'b1 || perr0 !== 1'b1 || rdata0 !== 8'h3C) begin
            failures++; $display("FAIL par_inject got v=%b perr=%b d=%h exp 1 1 3c", rvalid0, perr0, rdata0);
        end
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rvalid0 !== 1'b1 || perr0 !== 1'b0) begin
            failures++; $display("FAIL par_clean got v=%b perr=%b exp 1 0", rvalid0, perr0);
        end
        tick();
`endif
    endtask

    task automatic test_reset_mid_clear;
        int n0, n2;
        init = 1'b1;
        tick();
        init = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy0 !== 1'b1 || rvalid0 !== 1'b0) begin
            failures++; $display("FAIL midclear_reset got busy=%b v=%b exp 1 0", busy0, rvalid0);
        end
        tick();
        rst_n = 1'b1;
        count_clear(n0, n2);
        checks++;
        if (n0 != 32 || n2 != 20) begin
            failures++; $display("FAIL midclear_restart got n0=%0d n2=%0d exp 32 20", n0, n2);
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_byte_enable();
        test_rdw();
        test_out_of_range();
        test_clear();
        test_parity();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
